pkt_rr_arb: RTL

Packet-aware round-robin arbiter with integrated data select for one output port of the crossbar switch. It shares a single downstream port among N requesters carrying sop/eop-framed packets. It locks the grant from the sop beat to the eop beat so packets never interleave, and advances priority after every packet. A stall watchdog aborts locks on stalled packets, and the block flags framing violations.

---
 rtl/pkt_rr_arb_if.sv | 30 +++
 rtl/pkt_rr_arb.sv | 126 ++++++++++++
 2 files changed

// File: rtl/pkt_rr_arb_if.sv
// Requester-side and downstream-side handshake bundle for one crossbar output port.
// The arbiter connects through the slave modport and the requester/sink side through master.
interface pkt_rr_arb_if #(
  parameter int unsigned WIDTH = 80,
  parameter int unsigned N     = 4
);
  localparam int unsigned SELW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_sop;
  logic [N-1:0]            in_eop;
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic                    out_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic                    out_sop;
  logic                    out_eop;
  logic [SELW-1:0]         out_sel;

  modport master (
    output in_data, in_sop, in_eop, in_valid, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_sel
  );

  modport slave (
    input  in_data, in_sop, in_eop, in_valid, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_sel
  );
endinterface

// File: rtl/pkt_rr_arb.sv
// Packet-locked round-robin arbiter with data select for one crossbar output port.
// The grant is held from sop to eop; a stall watchdog aborts dead locks and framing faults are flagged.
module pkt_rr_arb #(
  parameter int unsigned WIDTH   = 80,
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic         clk,
  input  logic         rst,
  pkt_rr_arb_if.slave  bus,
  output logic         busy,
  input  logic         err_clr,
  output logic [N-1:0] proto_err,
  output logic         timeout_err
);
  localparam int unsigned SELW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNTW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned CNT_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [SELW-1:0] g;
  logic [SELW-1:0] ptr;
  logic [CNTW-1:0] cnt;
  logic            first;

  logic [N-1:0]    cand;
  logic            win_found;
  logic [SELW-1:0] win_idx;
  logic            g_valid;
  logic            g_sop;
  logic            g_eop;
  logic            accept;
  logic            wd_fire;
  logic [N-1:0]    lock_mask;
  logic [N-1:0]    idle_err;
  logic [N-1:0]    sop_err;
  logic [SELW-1:0] nxt_ptr;

  assign cand    = bus.in_valid & bus.in_sop;
  assign g_valid = bus.in_valid[g];
  assign g_sop   = bus.in_sop[g];
  assign g_eop   = bus.in_eop[g];
  assign accept  = (state == LOCK) && g_valid && bus.out_ready;
  assign nxt_ptr = (32'(g) == N - 1) ? '0 : g + SELW'(1);
  assign wd_fire = (TIMEOUT != 0) && (state == LOCK) && !g_valid && (cnt == CNTW'(CNT_LIM));

  // First sop candidate at or after ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!win_found && cand[(32'(ptr) + k) % N]) begin
        win_found = 1'b1;
        win_idx   = SELW'((32'(ptr) + k) % N);
      end
    end
  end

  // Error sources: stray non-sop beats from unlocked requesters, repeated sop inside a packet.
  always_comb begin
    lock_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      lock_mask[i] = (state == LOCK) && (32'(g) == i);
    end
    idle_err = bus.in_valid & ~bus.in_sop & ~lock_mask;
    sop_err  = lock_mask & {N{accept && g_sop && !first}};
  end

  // Zero-latency datapath and handshake while locked.
  always_comb begin
    bus.in_ready  = '0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    if (state == LOCK) begin
      bus.in_ready[g] = bus.out_ready;
      bus.out_valid   = g_valid;
      busy            = 1'b1;
    end
  end

  assign bus.out_data = bus.in_data[g];
  assign bus.out_sop  = g_sop;
  assign bus.out_eop  = g_eop;
  assign bus.out_sel  = g;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      g           <= '0;
      ptr         <= '0;
      cnt         <= '0;
      first       <= 1'b0;
      proto_err   <= '0;
      timeout_err <= 1'b0;
    end else begin
      // Setting wins over clearing in the same cycle.
      proto_err   <= (proto_err & ~{N{err_clr}}) | idle_err | sop_err;
      timeout_err <= (timeout_err & ~err_clr) | wd_fire;

      if (state == IDLE) begin
        if (win_found) begin
          state <= LOCK;
          g     <= win_idx;
          cnt   <= '0;
          first <= 1'b1;
        end
      end else begin
        if (accept) begin
          first <= 1'b0;
        end
        // Stall counter only runs while the locked requester is silent; backpressure does not count.
        if (g_valid) begin
          cnt <= '0;
        end else if (cnt != CNTW'(CNT_LIM)) begin
          cnt <= cnt + CNTW'(1);
        end
        if ((accept && g_eop) || wd_fire) begin
          state <= IDLE;
          ptr   <= nxt_ptr;
        end
      end
    end
  end
endmodule
